mem_bus_master: RTL and testbench
=================================

Name: mem_bus_master

Overview:
- Initiator side of the CPU's asynchronous, level-strobed memory interface: read/write strobes, address and data lines.
- Accepts single-word read/write requests from the core over a valid/ready handshake.
- Sequences address setup, strobe and hold phases on the clock, captures read data and returns a one-cycle response pulse.
- Sits between the CPU control unit (fetch/load/store) and the memory block.

Parameters:
- MEM_ADDR_SIZE, 6, address width in bits.
- WORD_SIZE, 16, data word width in bits.
- STROBE_CYCLES, 2, number of cycles mem_read/mem_write stay high; legal range 1..15.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  core presents a request.
- req_ready  output  1  master can accept a request this cycle.
- req_write  input  1  1 = write, 0 = read; sampled at accept.
- req_addr  input  MEM_ADDR_SIZE  word address; sampled at accept.
- req_wdata  input  WORD_SIZE  write data; sampled at accept.
- resp_valid  output  1  one-cycle pulse when the transaction completes (read or write).
- resp_rdata  output  WORD_SIZE  last captured read data.
- mem_read  output  1  read strobe to memory.
- mem_write  output  1  write strobe to memory.
- mem_address  output  MEM_ADDR_SIZE  address to memory.
- mem_data_out  output  WORD_SIZE  write data to memory.
- mem_data_in  input  WORD_SIZE  read data from memory; high-Z outside a read strobe.

Behaviour:
- Reset (synchronous, active-high): state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; mem_read=0; mem_write=0; mem_address=0; mem_data_out=0; strobe counter=0.
- Accept: a request is accepted on a rising edge where req_valid && req_ready.
  - req_write, req_addr and req_wdata are latched into mem_address, mem_data_out and an op register at that edge.
- States:
  - IDLE: req_ready=1, strobes low. Accept -> SETUP.
  - SETUP (1 cycle): address and data driven, strobes low, req_ready=0. -> STROBE with counter=STROBE_CYCLES-1.
  - STROBE (STROBE_CYCLES cycles): mem_read=1 if op is read, otherwise mem_write=1; req_ready=0. Counter decrements each cycle. At the edge where counter==0:
    - for a read, mem_data_in is captured into resp_rdata;
    - state -> HOLD.
  - HOLD (1 cycle): strobes low, mem_address and mem_data_out unchanged, resp_valid=1, req_ready=1.
    - If a request is accepted -> SETUP with the new request latched at that edge.
    - Otherwise -> IDLE.
- Invariants:
  - mem_read and mem_write are never both high.
  - Strobes are never high in IDLE, SETUP or HOLD.
  - mem_address and mem_data_out change only at accept edges, never while a strobe is high.
- Latency: with accept edge E0, resp_valid is high in cycle STROBE_CYCLES+2 after E0; default 4.
- Throughput: back-to-back requests complete every STROBE_CYCLES+2 cycles, because HOLD accepts the next request.
- resp_rdata:
  - updated only by reads;
  - a write leaves it unchanged;
  - it holds its value between transactions;
  - a high-Z/X mem_data_in outside a read strobe is never sampled.
- req_valid while req_ready=0: ignored, no latching; the core must hold the request until accepted.
- Reset mid-transaction (any state): strobes drop at that edge, no resp_valid is issued, the transaction is discarded, and all outputs return to reset values.
- Address and data: no arithmetic; addresses pass through unchanged. Full MEM_ADDR_SIZE range is legal, including 0 and 2^MEM_ADDR_SIZE-1.

Decomposition:
- Shared package cpu_mem_pkg holds:
  - MEM_ADDR_SIZE and WORD_SIZE defaults (shared with memory and CPU);
  - state encoding constants ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD (2-bit);
  - op encoding OP_READ=0, OP_WRITE=1.
- Sub-module mem_strobe_timer: loadable 4-bit down-counter with a done flag, used for the STROBE phase.
- The remainder is a single FSM.

Test Plan:
- Memory pre-initialised (word 0 = 16'h0450); read addr 0 -> resp_valid in cycle 4 after accept, resp_rdata=16'h0450; mem_read high for exactly 2 cycles, preceded and followed by a low-strobe cycle.
- Write addr 5 data 16'h1234, then read addr 5:
  - write resp_valid pulses and resp_rdata keeps its prior value;
  - the read returns 16'h1234.
- req_valid held high with reads to addr 1, 2, 3 back-to-back:
  - responses arrive 4 cycles apart;
  - mem_address changes only in non-strobe cycles.
- Reset asserted during the second STROBE cycle of a write to addr 6:
  - mem_write is 0 the next cycle;
  - no resp_valid;
  - req_ready=1;
  - mem_address=0.
- Request offered while busy (in SETUP) stays unaccepted until HOLD, then completes correctly; mem_read and mem_write are never both high (assertion).
- STROBE_CYCLES=1 build: read addr 63 (memory holds 16'h003F) -> resp_valid in cycle 3 after accept, resp_rdata=16'h003F.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Definitions shared by the CPU, the memory block and the memory bus master:
// default bus widths, bus master state encoding and transfer op encoding.
package cpu_mem_pkg;

  localparam int unsigned DEF_MEM_ADDR_SIZE = 6;
  localparam int unsigned DEF_WORD_SIZE     = 16;

  // Width of the strobe phase counter; covers STROBE_CYCLES up to 15.
  localparam int unsigned TIMER_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/mem_strobe_timer.sv
// Loadable down-counter timing the strobe phase; done_o is high while the
// count is zero, i.e. during the final strobe cycle.
module mem_strobe_timer
  import cpu_mem_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   load_i,
  input  logic [TIMER_WIDTH-1:0] load_value_i,
  input  logic                   dec_i,
  output logic                   done_o
);

  logic [TIMER_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - TIMER_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/mem_bus_master.sv
// Initiator for the level-strobed memory interface: accepts one-word requests,
// runs setup / strobe / hold phases and returns a one-cycle response pulse.
module mem_bus_master
  import cpu_mem_pkg::*;
#(
  parameter int unsigned MEM_ADDR_SIZE = DEF_MEM_ADDR_SIZE,
  parameter int unsigned WORD_SIZE     = DEF_WORD_SIZE,
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [MEM_ADDR_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0]     req_wdata,
  output logic                     resp_valid,
  output logic [WORD_SIZE-1:0]     resp_rdata,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [MEM_ADDR_SIZE-1:0] mem_address,
  output logic [WORD_SIZE-1:0]     mem_data_out,
  input  logic [WORD_SIZE-1:0]     mem_data_in
);

  localparam logic [TIMER_WIDTH-1:0] StrobeLoad = TIMER_WIDTH'(STROBE_CYCLES - 1);

  state_e                   state_q, state_d;
  logic                     op_q;
  logic [MEM_ADDR_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0]     wdata_q;
  logic [WORD_SIZE-1:0]     rdata_q;
  logic                     accept;
  logic                     capture;
  logic                     timer_load;
  logic                     timer_dec;
  logic                     strobe_done;

  mem_strobe_timer u_strobe_timer (
    .clk_i        (clk),
    .reset_i      (reset),
    .load_i       (timer_load),
    .load_value_i (StrobeLoad),
    .dec_i        (timer_dec),
    .done_o       (strobe_done)
  );

  always_comb begin
    state_d    = state_q;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        timer_load = 1'b1;
        state_d    = ST_STROBE;
      end
      ST_STROBE: begin
        mem_read  = (op_q == OP_READ);
        mem_write = (op_q == OP_WRITE);
        timer_dec = 1'b1;
        if (strobe_done) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        req_ready  = 1'b1;
        resp_valid = 1'b1;
        state_d    = req_valid ? ST_SETUP : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept = req_valid && req_ready;
  // Read data is only sampled on the last strobe cycle, never while the bus floats.
  assign capture = (state_q == ST_STROBE) && strobe_done && (op_q == OP_READ);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= req_write ? OP_WRITE : OP_READ;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (capture) rdata_q <= mem_data_in;
    end
  end

  assign mem_address  = addr_q;
  assign mem_data_out = wdata_q;
  assign resp_rdata   = rdata_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master: vector table, hand-written corner
// sequences and random transactions against a word-level memory model.
module tb_mem_bus_master;

  localparam int SC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, mem_init;
  logic        req_valid, req_ready, req_write, resp_valid;
  logic [5:0]  req_addr, mem_address;
  logic [15:0] req_wdata, resp_rdata, mem_data_out, mem_data_in;
  logic        mem_read, mem_write;

  logic        s1_req_valid, s1_req_ready, s1_req_write, s1_resp_valid;
  logic [5:0]  s1_req_addr, s1_mem_address;
  logic [15:0] s1_req_wdata, s1_resp_rdata, s1_mem_data_out, s1_mem_data_in;
  logic        s1_mem_read, s1_mem_write;

  mem_bus_master dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_data_out (mem_data_out),
    .mem_data_in  (mem_data_in)
  );

  mem_bus_master #(.STROBE_CYCLES(1)) dut_s1 (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (s1_req_valid),
    .req_ready    (s1_req_ready),
    .req_write    (s1_req_write),
    .req_addr     (s1_req_addr),
    .req_wdata    (s1_req_wdata),
    .resp_valid   (s1_resp_valid),
    .resp_rdata   (s1_resp_rdata),
    .mem_read     (s1_mem_read),
    .mem_write    (s1_mem_write),
    .mem_address  (s1_mem_address),
    .mem_data_out (s1_mem_data_out),
    .mem_data_in  (s1_mem_data_in)
  );

  // Memories: driven only during a read strobe, garbage otherwise.
  logic [15:0] mem0 [64];
  logic [15:0] mem1 [64];

  function automatic logic [15:0] init_word(input int i);
    return (i == 0) ? 16'h0450 : 16'(i);
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) begin
        mem0[i] <= init_word(i);
        mem1[i] <= init_word(i);
      end
    end else begin
      if (mem_write) mem0[mem_address] <= mem_data_out;
      if (s1_mem_write) mem1[s1_mem_address] <= s1_mem_data_out;
    end
  end

  assign mem_data_in    = mem_read ? mem0[mem_address] : 16'hDEAD;
  assign s1_mem_data_in = s1_mem_read ? mem1[s1_mem_address] : 16'hBEEF;

  int excl_fail = 0;
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(mem_read && mem_write)) else excl_fail <= excl_fail + 1;
      assert (!(s1_mem_read && s1_mem_write)) else excl_fail <= excl_fail + 1;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level reference: memory contents and last read word.
  logic [15:0] ref_mem [64];
  logic [15:0] ref_rdata;

  task automatic model(input logic w, input logic [5:0] a, input logic [15:0] d,
                       output logic [15:0] exp);
    if (w) ref_mem[a] = d;
    else ref_rdata = ref_mem[a];
    exp = ref_rdata;
  endtask

  // One isolated transaction on the default build; checks timing and strobes.
  task automatic txn(input string tag, input logic w, input logic [5:0] a,
                     input logic [15:0] d, output logic [15:0] rdata);
    int          wait_n, lat;
    logic [31:0] mask;
    bit          ok, got;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    wait_n = 0;
    while (!req_ready && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    chk({tag, "_accept"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1; mask = '0; ok = 1'b1; got = 1'b0;
    while (lat < 20 && !got) begin
      if (mem_read || mem_write) begin
        mask[lat] = 1'b1;
        if (mem_address !== a || mem_read !== !w || (w && mem_data_out !== d)) ok = 1'b0;
      end
      if (resp_valid) got = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(SC + 2));
    chk({tag, "_strobe_cycles"}, mask, ((32'd1 << SC) - 32'd1) << 2);
    chk({tag, "_bus_values"}, 32'(ok), 32'd1);
    rdata = resp_rdata;
    @(negedge clk);
    chk({tag, "_resp_pulse"}, 32'(resp_valid), 32'd0);
  endtask

  typedef struct {
    logic        w;
    logic [5:0]  a;
    logic [15:0] d;
    logic [15:0] exp;
  } vec_t;

  vec_t        vecs [8];
  logic [15:0] r, e;
  int          resp_cyc [$];
  logic [15:0] resp_dat [$];
  int          acc_n, addr_bad, lat, quiet_bad;
  logic [5:0]  prev_addr;
  logic [31:0] mask;
  bit          acc, got;
  logic [5:0]  s1_addrs [2];
  logic [15:0] s1_exps [2];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; mem_init = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    s1_req_valid = 1'b0; s1_req_write = 1'b0; s1_req_addr = '0; s1_req_wdata = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    ref_rdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(req_ready), 32'd1);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_rdata", 32'(resp_rdata), 32'd0);
    chk("reset_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("reset_address", 32'(mem_address), 32'd0);
    chk("reset_data_out", 32'(mem_data_out), 32'd0);
    chk("reset_s1_ready", 32'(s1_req_ready), 32'd1);
    reset = 1'b0; mem_init = 1'b0;

    // Vector table
    vecs[0] = '{w: 1'b0, a: 6'd0,  d: 16'h0000, exp: 16'h0450};
    vecs[1] = '{w: 1'b1, a: 6'd5,  d: 16'h1234, exp: 16'h0450};
    vecs[2] = '{w: 1'b0, a: 6'd5,  d: 16'h0000, exp: 16'h1234};
    vecs[3] = '{w: 1'b0, a: 6'd63, d: 16'h0000, exp: 16'h003F};
    vecs[4] = '{w: 1'b1, a: 6'd63, d: 16'hFFFF, exp: 16'h003F};
    vecs[5] = '{w: 1'b0, a: 6'd63, d: 16'h0000, exp: 16'hFFFF};
    vecs[6] = '{w: 1'b1, a: 6'd0,  d: 16'h0000, exp: 16'hFFFF};
    vecs[7] = '{w: 1'b0, a: 6'd0,  d: 16'h0000, exp: 16'h0000};
    for (int i = 0; i < 8; i++) begin
      txn($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].d, r);
      model(vecs[i].w, vecs[i].a, vecs[i].d, e);
      chk($sformatf("vec%0d_rdata", i), 32'(r), 32'(vecs[i].exp));
    end

    // Back-to-back reads 1,2,3 with req_valid held high
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 6'd1;
    acc_n = 0; addr_bad = 0; prev_addr = mem_address;
    for (int i = 0; i < 30; i++) begin
      if (resp_valid) begin
        resp_cyc.push_back(i);
        resp_dat.push_back(resp_rdata);
      end
      if ((mem_read || mem_write) && mem_address !== prev_addr) addr_bad++;
      prev_addr = mem_address;
      acc = req_valid && req_ready;
      @(negedge clk);
      if (acc) begin
        acc_n++;
        if (acc_n < 3) req_addr = 6'(acc_n + 1);
        else req_valid = 1'b0;
      end
    end
    for (int k = 1; k <= 3; k++) model(1'b0, 6'(k), 16'h0, e);
    chk("b2b_responses", 32'(resp_cyc.size()), 32'd3);
    chk("b2b_addr_stable", 32'(addr_bad), 32'd0);
    if (resp_cyc.size() == 3) begin
      chk("b2b_first_lat", 32'(resp_cyc[0]), 32'(SC + 2));
      chk("b2b_gap1", 32'(resp_cyc[1] - resp_cyc[0]), 32'(SC + 2));
      chk("b2b_gap2", 32'(resp_cyc[2] - resp_cyc[1]), 32'(SC + 2));
      for (int k = 0; k < 3; k++)
        chk($sformatf("b2b_rdata%0d", k), 32'(resp_dat[k]), 32'(k + 1));
    end

    // Request offered while busy: held until HOLD, then completes
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 6'd2;
    chk("busy_idle_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_write = 1'b1; req_addr = 6'd9; req_wdata = 16'hABCD;
    chk("busy_setup_ready", 32'(req_ready), 32'd0);
    for (int k = 0; k < SC; k++) begin
      @(negedge clk);
      chk("busy_strobe_ready", 32'(req_ready), 32'd0);
      chk("busy_strobe_addr", {25'd0, mem_read, mem_address}, {25'd0, 1'b1, 6'd2});
    end
    @(negedge clk);
    chk("busy_hold_resp", 32'(resp_valid), 32'd1);
    chk("busy_hold_rdata", 32'(resp_rdata), 32'h0002);
    chk("busy_hold_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("busy_wr_setup", {9'd0, mem_write, mem_address, mem_data_out},
        {9'd0, 1'b0, 6'd9, 16'hABCD});
    lat = 1; got = 1'b0;
    while (lat < 20 && !got) begin
      if (resp_valid) got = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    chk("busy_wr_latency", 32'(lat), 32'(SC + 2));
    chk("busy_wr_rdata_kept", 32'(resp_rdata), 32'h0002);
    model(1'b0, 6'd2, 16'h0, e);
    model(1'b1, 6'd9, 16'hABCD, e);
    txn("busy_rd9", 1'b0, 6'd9, 16'h0, r);
    chk("busy_rd9_rdata", 32'(r), 32'hABCD);
    model(1'b0, 6'd9, 16'h0, e);

    // Randomised traffic against the model
    for (int i = 0; i < 40; i++) begin
      logic       w;
      logic [5:0] a;
      logic [15:0] d;
      w = 1'($urandom_range(0, 1));
      a = 6'($urandom_range(0, 63));
      if (i % 10 == 3) a = 6'd0;
      if (i % 10 == 7) a = 6'd63;
      d = 16'($urandom);
      txn($sformatf("rnd%0d", i), w, a, d, r);
      model(w, a, d, e);
      chk($sformatf("rnd%0d_rdata", i), 32'(r), 32'(e));
    end

    // Reset during the second strobe cycle of a write to addr 6
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 6'd6; req_wdata = 16'h5A5A;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_strobe1", 32'(mem_write), 32'd1);
    @(negedge clk);
    chk("rst_strobe2", 32'(mem_write), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_address", 32'(mem_address), 32'd0);
    chk("rst_data_out", 32'(mem_data_out), 32'd0);
    chk("rst_rdata", 32'(resp_rdata), 32'd0);
    reset = 1'b0;
    quiet_bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid || mem_read || mem_write) quiet_bad++;
    end
    chk("rst_quiet", 32'(quiet_bad), 32'd0);
    ref_rdata = '0;
    ref_mem[6] = 16'h5A5A;  // first strobe edge already wrote the word

    // STROBE_CYCLES=1 build
    s1_addrs[0] = 6'd63; s1_exps[0] = 16'h003F;
    s1_addrs[1] = 6'd0;  s1_exps[1] = 16'h0450;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      s1_req_valid = 1'b1; s1_req_write = 1'b0; s1_req_addr = s1_addrs[k];
      chk($sformatf("s1_%0d_ready", k), 32'(s1_req_ready), 32'd1);
      @(negedge clk);
      s1_req_valid = 1'b0;
      lat = 1; mask = '0; got = 1'b0;
      while (lat < 20 && !got) begin
        if (s1_mem_read || s1_mem_write) mask[lat] = 1'b1;
        if (s1_resp_valid) got = 1'b1;
        else begin
          @(negedge clk);
          lat++;
        end
      end
      chk($sformatf("s1_%0d_latency", k), 32'(lat), 32'd3);
      chk($sformatf("s1_%0d_strobe", k), mask, 32'b100);
      chk($sformatf("s1_%0d_rdata", k), 32'(s1_resp_rdata), 32'(s1_exps[k]));
    end

    chk("strobe_exclusive", 32'(excl_fail), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
